// File: rtl/lc3_mem_access_ctrl.sv
// LC-3 memory-access sequencer: one read/write per request against a ready-signalled memory, feeding the MDR on reads.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS wait-cycle limit that aborts with Error.
module lc3_mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        RW,
    input  logic [15:0] Addr,
    input  logic [15:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic        Error,
    output logic [15:0] MDR_D,
    output logic        MDR_WE,
    output logic        Mem_En,
    output logic        Mem_WE,
    output logic [15:0] Mem_Addr,
    output logic [15:0] Mem_WData,
    input  logic [15:0] Mem_RData,
    input  logic        Mem_R,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    // Handshake: a request is taken only when Start=1 in IDLE (Busy=0); the
    // memory completes an access on any ACCESS-state edge where Mem_R=1.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES outside 1..2^CNT_W-1");
    end

    logic [1:0]  state;
    logic        rw_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] mdr_q;
    logic        err_q;
    logic        timeout_hit;

`ifdef MEM_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;

    // Mem_R has priority: a ready on the limit edge still completes normally.
    assign timeout_hit = (state == ACCESS) && !Mem_R && (cnt_q == CNT_LIM);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (state == IDLE && Start) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (state == ACCESS && !Mem_R) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_q       = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mdr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        addr_q  <= Addr;
                        rw_q    <= RW;
                        wdata_q <= RW ? WrData : 16'h0000;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (Mem_R) begin
                        if (!rw_q) mdr_q <= Mem_RData;
                        state <= DONE;
                    end else if (timeout_hit) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is a register or a pure decode of registers.
    assign Busy      = (state != IDLE);
    assign Done      = (state == DONE);
    assign Error     = err_q;
    assign MDR_D     = mdr_q;
    assign MDR_WE    = (state == DONE) && !rw_q && !err_q;
    assign Mem_En    = (state == ACCESS);
    assign Mem_WE    = (state == ACCESS) && rw_q;
    assign Mem_Addr  = addr_q;
    assign Mem_WData = wdata_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_lc3_mem_access_ctrl.sv
// Bench for lc3_mem_access_ctrl: scenario tasks, read-data scoreboard queue, one summary line.
module tb_lc3_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] wrdata = '0;
    logic        busy, done, error, mdr_we, mem_en, mem_we;
    logic [15:0] mdr_d, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_r = 1'b0;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    lc3_mem_access_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .RW(rw), .Addr(addr), .WrData(wrdata),
        .Busy(busy), .Done(done), .Error(error), .MDR_D(mdr_d), .MDR_WE(mdr_we),
        .Mem_En(mem_en), .Mem_WE(mem_we), .Mem_Addr(mem_addr), .Mem_WData(mem_wdata),
        .Mem_RData(mem_rdata), .Mem_R(mem_r), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, done, error, mdr_we, mem_en, mem_we, mdr_d, mem_addr, mem_wdata, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b mdr_we=%b en=%b we=%b mdr=%h addr=%h wd=%h st=%0d, need all 0",
                     busy, done, error, mdr_we, mem_en, mem_we, mdr_d, mem_addr, mem_wdata, dbg_state);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b st=%0d, need 0/0", busy, dbg_state);
        end
    endtask

    task automatic test_read();
        logic [15:0] e;
        start = 1'b1; rw = 1'b0; addr = 16'h3000; mem_r = 1'b1; mem_rdata = 16'hBEEF;
        exp_q.push_back(16'hBEEF);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if ({mem_en, busy, mem_we, done, mem_addr, mem_wdata} !== {4'b1100, 16'h3000, 16'h0000}) begin
            n_fail++;
            $display("FAIL read_access: en=%b busy=%b we=%b done=%b addr=%h wd=%h, need 1 1 0 0 3000 0000",
                     mem_en, busy, mem_we, done, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if ({done, mdr_we, mem_en, busy} !== 4'b1101) begin
            n_fail++;
            $display("FAIL read_done: done=%b mdr_we=%b en=%b busy=%b, need 1 1 0 1", done, mdr_we, mem_en, busy);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL read_data: scoreboard empty, got mdr=%h", mdr_d);
        end else begin
            e = exp_q.pop_front();
            if (mdr_d !== e) begin
                n_fail++;
                $display("FAIL read_data: mdr=%h, need %h", mdr_d, e);
            end
        end
        mem_r = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, done, mdr_we} !== 3'b000 || mdr_d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_idle: busy=%b done=%b mdr_we=%b mdr=%h, need 0 0 0 beef", busy, done, mdr_we, mdr_d);
        end
    endtask

    task automatic test_write();
        int en_cycles = 0;
        int bad = 0;
        start = 1'b1; rw = 1'b1; addr = 16'hFE06; wrdata = 16'h0041; mem_r = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_en === 1'b1) en_cycles++;
            if (mem_we !== 1'b1 || mem_wdata !== 16'h0041 || mem_addr !== 16'hFE06 || done !== 1'b0) bad++;
            mem_r = (i == 4);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL write_access: %0d bad ACCESS cycles, need 0", bad);
        end
        @(negedge clk);
        mem_r = 1'b0;
        if (mem_en === 1'b1) en_cycles++;
        n_checks++;
        if ({done, mdr_we, mem_en, mem_we} !== 4'b1000 || mdr_d !== 16'hBEEF || mem_wdata !== 16'h0041) begin
            n_fail++;
            $display("FAIL write_done: done=%b mdr_we=%b en=%b we=%b mdr=%h wd=%h, need 1 0 0 0 beef 0041",
                     done, mdr_we, mem_en, mem_we, mdr_d, mem_wdata);
        end
        @(negedge clk);
        if (mem_en === 1'b1) en_cycles++;
        n_checks++;
        if (en_cycles != 5 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL write_len: mem_en cycles=%0d busy=%b done=%b, need 5 0 0", en_cycles, busy, done);
        end
    endtask

    task automatic test_start_ignored();
        logic [15:0] e;
        int done_cnt = 0;
        start = 1'b1; rw = 1'b0; addr = 16'h1234; mem_r = 1'b0;
        exp_q.push_back(16'hCAFE);
        @(negedge clk);
        addr = 16'h5555;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (mem_addr !== 16'h1234 || mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL ignore_access: addr=%h en=%b, need 1234 1", mem_addr, mem_en);
        end
        mem_r = 1'b1; mem_rdata = 16'hCAFE;
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
        start = 1'b1; addr = 16'h7777; mem_r = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL ignore_data: scoreboard empty, got mdr=%h", mdr_d);
        end else begin
            e = exp_q.pop_front();
            if (mdr_d !== e || mdr_we !== 1'b1) begin
                n_fail++;
                $display("FAIL ignore_data: mdr=%h mdr_we=%b, need %h 1", mdr_d, mdr_we, e);
            end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) done_cnt++;
        end
        n_checks++;
        if (busy !== 1'b0 || mem_addr !== 16'h1234 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL ignore_queue: busy=%b addr=%h dones=%0d, need 0 1234 1", busy, mem_addr, done_cnt);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] e;
        int we_cnt = 0;
        start = 1'b1; rw = 1'b0; addr = 16'h4000; mem_r = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || mem_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: busy=%b en=%b, need 1 1", busy, mem_en);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, error, mdr_we, mem_en, mem_we, mdr_d, mem_addr, mem_wdata} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b done=%b en=%b mdr=%h addr=%h wd=%h, need all 0",
                     busy, done, mem_en, mdr_d, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        if (mdr_we === 1'b1) we_cnt++;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_idle: busy=%b, need 0", busy);
        end
        start = 1'b1; addr = 16'h0005; mem_r = 1'b1; mem_rdata = 16'h1111;
        exp_q.push_back(16'h1111);
        @(negedge clk);
        start = 1'b0;
        if (mdr_we === 1'b1) we_cnt++;
        n_checks++;
        if (mem_en !== 1'b1 || mem_addr !== 16'h0005) begin
            n_fail++;
            $display("FAIL rst_new_access: en=%b addr=%h, need 1 0005", mem_en, mem_addr);
        end
        @(negedge clk);
        if (mdr_we === 1'b1) we_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rst_new_data: scoreboard empty, got mdr=%h", mdr_d);
        end else begin
            e = exp_q.pop_front();
            if (mdr_d !== e || done !== 1'b1) begin
                n_fail++;
                $display("FAIL rst_new_data: mdr=%h done=%b, need %h 1", mdr_d, done, e);
            end
        end
        mem_r = 1'b0;
        @(negedge clk);
        if (mdr_we === 1'b1) we_cnt++;
        n_checks++;
        if (we_cnt != 1) begin
            n_fail++;
            $display("FAIL rst_mdr_we_count: %0d pulses, need 1", we_cnt);
        end
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] e;
        int en_cycles = 0;
        start = 1'b1; rw = 1'b0; addr = 16'h2000; mem_r = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (mem_en === 1'b1) en_cycles++;
        end
        @(negedge clk);
        n_checks++;
        if (en_cycles != 4 || {done, error, mdr_we} !== 3'b110 || mdr_d !== 16'h1111) begin
            n_fail++;
            $display("FAIL timeout_done: en cycles=%0d done=%b err=%b mdr_we=%b mdr=%h, need 4 1 1 0 1111",
                     en_cycles, done, error, mdr_we, mdr_d);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: busy=%b err=%b, need 0 1", busy, error);
        end
        start = 1'b1; mem_r = 1'b0; mem_rdata = 16'h3333;
        exp_q.push_back(16'h3333);
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err=%b, need 0", error);
        end
        for (int i = 0; i < 3; i++) begin
            mem_r = (i == 2);
            @(negedge clk);
        end
        mem_r = 1'b0;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL timeout_edge: scoreboard empty, got mdr=%h", mdr_d);
        end else begin
            e = exp_q.pop_front();
            if ({done, error, mdr_we} !== 3'b101 || mdr_d !== e) begin
                n_fail++;
                $display("FAIL timeout_edge: done=%b err=%b mdr_we=%b mdr=%h, need 1 0 1 %h",
                         done, error, mdr_we, mdr_d, e);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_start_ignored();
        test_reset_mid_access();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
